// File: rtl/project_mux_pkg.sv
// project_mux_pkg: shared types, default constants and id decode for project_io_mux
package project_mux_pkg;
  typedef enum logic [1:0] {OFF, GUARD, ON} state_e;
  localparam int DEF_NUM_PROJECTS = 8;
  localparam int DEF_IO_WIDTH     = 38;
  localparam int DEF_LA_WIDTH     = 32;
  localparam int DEF_GUARD_CYCLES = 4;
  localparam int MAX_PROJECTS     = 32;
  function automatic logic [MAX_PROJECTS-1:0] onehot_id(input logic [5:0] id);
    return id[5] ? '0 : (MAX_PROJECTS'(1) << id[4:0]);
  endfunction
endpackage

// File: rtl/project_slice_mux.sv
// project_slice_mux: combinational N:1 selector of W-bit slices
//   d_i [N*W]  packed slices, slice i at [i*W +: W]
//   sel_i [SW] slice index; out-of-range selects all zero
//   y_o [W]    selected slice
module project_slice_mux #(
  parameter int N  = 8,
  parameter int W  = 38,
  parameter int SW = 4
) (
  input  logic [N*W-1:0] d_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   y_o
);
  always_comb begin
    y_o = '0;
    for (int i = 0; i < N; i++)
      if (sel_i == SW'(i)) y_o = d_i[i*W +: W];
  end
endmodule

// File: rtl/project_io_mux.sv
// project_io_mux: arbitrates shared user IOs and LA bank 1 among wrapped projects
//   wb_clk_i, wb_rst_ni            clock, async active-low reset
//   req_valid/req_en/req_id        selection request (en=0 deselects all)
//   req_ready                      request can be accepted (low during guard)
//   active, cur_id, sel_on         one-hot owner, owner id, ownership flag
//   err_bad_id, err_clr            sticky out-of-range id flag and its clear
//   prj_io_out/prj_io_oeb/prj_la_out  per-project outputs
//   io_out/io_oeb/la_data_out      to pads and LA bank 1
module project_io_mux
  import project_mux_pkg::*;
#(
  parameter int NUM_PROJECTS = DEF_NUM_PROJECTS,
  parameter int IO_WIDTH     = DEF_IO_WIDTH,
  parameter int LA_WIDTH     = DEF_LA_WIDTH,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int ID_W         = $clog2(NUM_PROJECTS) + 1
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         req_valid,
  input  logic                         req_en,
  input  logic [ID_W-1:0]              req_id,
  output logic                         req_ready,
  output logic [NUM_PROJECTS-1:0]      active,
  output logic [ID_W-1:0]              cur_id,
  output logic                         sel_on,
  output logic                         err_bad_id,
  input  logic                         err_clr,
  input  logic [NUM_PROJECTS*IO_WIDTH-1:0] prj_io_out,
  input  logic [NUM_PROJECTS*IO_WIDTH-1:0] prj_io_oeb,
  input  logic [NUM_PROJECTS*LA_WIDTH-1:0] prj_la_out,
  output logic [IO_WIDTH-1:0]          io_out,
  output logic [IO_WIDTH-1:0]          io_oeb,
  output logic [LA_WIDTH-1:0]          la_data_out
);
  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic                    tgt_en_q;
  logic [ID_W-1:0]         tgt_id_q;
  logic [ID_W-1:0]         cur_id_q;
  logic [NUM_PROJECTS-1:0] active_q;
  logic                    err_q;
  logic                    accept;
  logic                    noop;
  logic                    tgt_ok;
  logic [IO_WIDTH-1:0]     mux_out;
  logic [IO_WIDTH-1:0]     mux_oeb;
  logic [LA_WIDTH-1:0]     mux_la;
  assign accept = req_valid && state_q != GUARD;
  // Re-selecting the current owner, or deselecting while already off, must not open a guard gap.
  assign noop   = (state_q == ON && req_en && req_id == cur_id_q) || (state_q == OFF && !req_en);
  assign tgt_ok = tgt_id_q < ID_W'(NUM_PROJECTS);
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      tgt_en_q <= 1'b0;
      tgt_id_q <= '0;
      cur_id_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // Clear first so a same-edge error set below takes precedence.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        GUARD: begin
          if (cnt_q == '0) begin
            if (tgt_en_q && tgt_ok) begin
              state_q  <= ON;
              active_q <= NUM_PROJECTS'(onehot_id(6'(tgt_id_q)));
              cur_id_q <= tgt_id_q;
            end else begin
              state_q <= OFF;
              if (tgt_en_q) err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          if (accept && !noop) begin
            state_q  <= GUARD;
            active_q <= '0;
            tgt_en_q <= req_en;
            tgt_id_q <= req_id;
            cnt_q    <= 8'(GUARD_CYCLES - 1);
          end
        end
      endcase
    end
  end
  project_slice_mux #(.N(NUM_PROJECTS), .W(IO_WIDTH), .SW(ID_W)) u_mux_out (
    .d_i(prj_io_out), .sel_i(cur_id_q), .y_o(mux_out)
  );
  project_slice_mux #(.N(NUM_PROJECTS), .W(IO_WIDTH), .SW(ID_W)) u_mux_oeb (
    .d_i(prj_io_oeb), .sel_i(cur_id_q), .y_o(mux_oeb)
  );
  project_slice_mux #(.N(NUM_PROJECTS), .W(LA_WIDTH), .SW(ID_W)) u_mux_la (
    .d_i(prj_la_out), .sel_i(cur_id_q), .y_o(mux_la)
  );
  assign sel_on      = state_q == ON;
  assign req_ready   = state_q != GUARD;
  assign active      = active_q;
  assign cur_id      = cur_id_q;
  assign err_bad_id  = err_q;
  // Pads are released (high-Z, outputs low) whenever no project owns them.
  assign io_out      = sel_on ? mux_out : '0;
  assign io_oeb      = sel_on ? mux_oeb : '1;
  assign la_data_out = sel_on ? mux_la  : '0;
endmodule

// File: tb/tb_project_io_mux.sv
// tb_project_io_mux: directed self-checking bench for project_io_mux
module tb_project_io_mux;
  localparam int N = 8, IW = 38, LW = 32, IDW = 4;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_en = 0, err_clr = 0;
  logic [IDW-1:0] req_id = '0;
  logic req_ready, sel_on, err_bad_id;
  logic [N-1:0] active;
  logic [IDW-1:0] cur_id;
  logic [N*IW-1:0] prj_io_out, prj_io_oeb;
  logic [N*LW-1:0] prj_la_out;
  logic [IW-1:0] io_out, io_oeb;
  logic [LW-1:0] la_data_out;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  project_io_mux dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_valid(req_valid), .req_en(req_en), .req_id(req_id),
    .req_ready(req_ready), .active(active), .cur_id(cur_id), .sel_on(sel_on),
    .err_bad_id(err_bad_id), .err_clr(err_clr), .prj_io_out(prj_io_out), .prj_io_oeb(prj_io_oeb),
    .prj_la_out(prj_la_out), .io_out(io_out), .io_oeb(io_oeb), .la_data_out(la_data_out)
  );
  function automatic logic [IW-1:0] iop(int p);
    return {6'(p), 32'hC0DE_0000 | 32'(p)};
  endfunction
  function automatic logic [LW-1:0] lap(int p);
    return 32'hA5A5_0000 + 32'(p);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic en, input logic [IDW-1:0] id);
    req_valid = 1; req_en = en; req_id = id;
    tick();
    req_valid = 0;
  endtask
  task automatic test_reset();
    checks++;
    if ({active, cur_id, sel_on, err_bad_id, req_ready} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_ctrl got %h want %h", {active, cur_id, sel_on, err_bad_id, req_ready}, {8'h00, 4'd0, 3'b001});
    end
    checks++;
    if ({io_out, io_oeb, la_data_out} !== {38'h0, {IW{1'b1}}, 32'h0}) begin
      errors++; $display("FAIL reset_pads got %h %h %h", io_out, io_oeb, la_data_out);
    end
  endtask
  task automatic test_select3();
    req(1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({active, sel_on, req_ready} !== 10'b0) begin
        errors++; $display("FAIL guard3_c%0d got %b want 0", i, {active, sel_on, req_ready});
      end
      tick();
    end
    checks++;
    if ({active, cur_id, sel_on, req_ready} !== {8'b0000_1000, 4'd3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL on3_ctrl got %h", {active, cur_id, sel_on, req_ready});
    end
    checks++;
    if ({io_out, io_oeb, la_data_out} !== {iop(3), ~iop(3), lap(3)}) begin
      errors++; $display("FAIL on3_pads got %h %h %h want %h %h %h", io_out, io_oeb, la_data_out, iop(3), ~iop(3), lap(3));
    end
  endtask
  task automatic test_noop();
    req(1, 4'd3);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({active, req_ready, sel_on} !== {8'h08, 1'b1, 1'b1}) begin
        errors++; $display("FAIL noop_c%0d got %h want 8,1,1", i, {active, req_ready, sel_on});
      end
      tick();
    end
  endtask
  task automatic test_switch5();
    req(1, 4'd5);
    checks++;
    if ({active, io_oeb, io_out} !== {8'h00, {IW{1'b1}}, 38'h0}) begin
      errors++; $display("FAIL sw5_hiz got %h %h %h", active, io_oeb, io_out);
    end
    tick();
    req_valid = 1; req_en = 1; req_id = 4'd1;
    tick();
    req_valid = 0;
    tick();
    checks++;
    if (active !== 8'h00) begin
      errors++; $display("FAIL sw5_guard got %h want 00", active);
    end
    tick();
    checks++;
    if ({active, cur_id} !== {8'b0010_0000, 4'd5}) begin
      errors++; $display("FAIL sw5_on got %h %0d want 20 5", active, cur_id);
    end
    tick();
    checks++;
    if ({active, req_ready, io_out} !== {8'h20, 1'b1, iop(5)}) begin
      errors++; $display("FAIL sw5_drop got %h %b %h", active, req_ready, io_out);
    end
  endtask
  task automatic test_bad_id();
    req(1, 4'd9);
    repeat (4) tick();
    checks++;
    if ({sel_on, active, err_bad_id, req_ready, io_oeb} !== {1'b0, 8'h00, 1'b1, 1'b1, {IW{1'b1}}}) begin
      errors++; $display("FAIL bad_id got sel=%b act=%h err=%b rdy=%b oeb=%h", sel_on, active, err_bad_id, req_ready, io_oeb);
    end
    tick();
    checks++;
    if (err_bad_id !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b want 1", err_bad_id);
    end
    err_clr = 1;
    tick();
    err_clr = 0;
    checks++;
    if (err_bad_id !== 1'b0) begin
      errors++; $display("FAIL err_clr got %b want 0", err_bad_id);
    end
  endtask
  task automatic test_deselect();
    req(0, 4'd0);
    checks++;
    if ({req_ready, sel_on} !== 2'b10) begin
      errors++; $display("FAIL off_noop got %b want 10", {req_ready, sel_on});
    end
    req(1, 4'd2);
    repeat (4) tick();
    checks++;
    if ({active, io_out, la_data_out} !== {8'h04, iop(2), lap(2)}) begin
      errors++; $display("FAIL on2 got %h %h %h", active, io_out, la_data_out);
    end
    req(0, 4'd0);
    checks++;
    if ({active, req_ready} !== 9'b0) begin
      errors++; $display("FAIL desel_guard got %h %b", active, req_ready);
    end
    repeat (4) tick();
    checks++;
    if ({sel_on, active, io_out, la_data_out, io_oeb, err_bad_id, req_ready} !== {1'b0, 8'h00, 38'h0, 32'h0, {IW{1'b1}}, 1'b0, 1'b1}) begin
      errors++; $display("FAIL desel_off got sel=%b act=%h out=%h la=%h oeb=%h err=%b rdy=%b", sel_on, active, io_out, la_data_out, io_oeb, err_bad_id, req_ready);
    end
  endtask
  task automatic test_async_reset();
    req(1, 4'd6);
    tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({active, cur_id, sel_on, req_ready, io_oeb, io_out} !== {8'h00, 4'd0, 1'b0, 1'b1, {IW{1'b1}}, 38'h0}) begin
      errors++; $display("FAIL rst_guard got act=%h id=%0d sel=%b rdy=%b", active, cur_id, sel_on, req_ready);
    end
    rst_n = 1;
    req(1, 4'd6);
    repeat (4) tick();
    checks++;
    if ({active, cur_id, io_out} !== {8'h40, 4'd6, iop(6)}) begin
      errors++; $display("FAIL on6 got %h %0d %h", active, cur_id, io_out);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({active, cur_id, sel_on, req_ready, io_oeb, io_out, la_data_out} !== {8'h00, 4'd0, 1'b0, 1'b1, {IW{1'b1}}, 38'h0, 32'h0}) begin
      errors++; $display("FAIL rst_on got act=%h id=%0d sel=%b oeb=%h la=%h", active, cur_id, sel_on, io_oeb, la_data_out);
    end
    rst_n = 1;
    req(1, 4'd1);
    checks++;
    if ({active, req_ready} !== 9'b0) begin
      errors++; $display("FAIL post_rst_guard got %h %b", active, req_ready);
    end
    repeat (4) tick();
    checks++;
    if ({active, cur_id, io_out, io_oeb} !== {8'h02, 4'd1, iop(1), ~iop(1)}) begin
      errors++; $display("FAIL post_rst_on got %h %0d %h %h", active, cur_id, io_out, io_oeb);
    end
  endtask
  initial begin
    for (int p = 0; p < N; p++) begin
      prj_io_out[p*IW +: IW] = iop(p);
      prj_io_oeb[p*IW +: IW] = ~iop(p);
      prj_la_out[p*LW +: LW] = lap(p);
    end
    #12;
    test_reset();
    rst_n = 1;
    tick();
    test_select3();
    test_noop();
    test_switch5();
    test_bad_id();
    test_deselect();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
